// File: rtl/fib_word_serializer.sv
// Parallel-to-serial transmitter for Fibonacci result words: LSB first, one bit per clk.
// Bit0 appears the cycle after the accepting edge; hold freezes shifting; load_ready is combinational.
module fib_word_serializer #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             sout_q;
    logic             vld_q;
    logic             last_q;
    logic             rdy_en_q;
    logic             accept;

    assign shreg_d = shreg_q >> 1;
    assign cnt_d   = cnt_q + CW'(1);

    // rdy_en_q keeps load_ready low until the first edge after CLR releases.
    assign load_ready = rdy_en_q &
                        ((state_q == IDLE) | ((state_q == SHIFT) & last_q & ~hold));
    assign accept     = load_valid & load_ready;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sout_q   <= 1'b0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        shreg_q <= data_in;
                        cnt_q   <= '0;
                        sout_q  <= data_in[0];
                        vld_q   <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!hold) begin
                        if (cnt_q == LAST_IDX) begin
                            if (accept) begin
                                shreg_q <= data_in;
                                cnt_q   <= '0;
                                sout_q  <= data_in[0];
                                last_q  <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                shreg_q <= '0;
                                cnt_q   <= '0;
                                sout_q  <= 1'b0;
                                vld_q   <= 1'b0;
                                last_q  <= 1'b0;
                            end
                        end else begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_d;
                            sout_q  <= shreg_d[0];
                            last_q  <= (cnt_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sout       = sout_q;
    assign sout_valid = vld_q;
    assign sout_last  = last_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_fib_word_serializer.sv
// Directed bench for fib_word_serializer (WIDTH=16): reset, single word, back-to-back, hold, CLR abort, hold in IDLE.
module tb_fib_word_serializer;

    logic        clk;
    logic        CLR;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] data_in;
    logic        hold;
    logic        sout;
    logic        sout_valid;
    logic        sout_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fib_word_serializer #(.WIDTH(16), .CW(5)) dut (
        .clk        (clk),
        .CLR        (CLR),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .hold       (hold),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " vld"}, 32'(sout_valid), 32'd0);
        chk({tag, " sout"}, 32'(sout), 32'd0);
        chk({tag, " last"}, 32'(sout_last), 32'd0);
    endtask

    // Word already accepted; load_valid low and hold low while bits stream out.
    task automatic expect_word(input logic [15:0] w, input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s bit%0d", tag, i), 32'(sout), 32'(w[i[3:0]]));
            chk($sformatf("%s vld%0d", tag, i), 32'(sout_valid), 32'd1);
            chk($sformatf("%s last%0d", tag, i), 32'(sout_last), 32'(i == 15));
            chk($sformatf("%s rdy%0d", tag, i), 32'(load_ready), 32'(i == 15));
            tick();
        end
        chk_idle({tag, " end"});
    endtask

    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] wc;
    logic        eb;

    initial begin
        CLR        = 1'b1;
        load_valid = 1'b0;
        data_in    = 16'h0000;
        hold       = 1'b0;

        // Reset state and ready gating around release
        tick();
        tick();
        chk_idle("rst");
        chk("rst rdy", 32'(load_ready), 32'd0);
        #3 CLR = 1'b0;
        #1 chk("rel rdy before edge", 32'(load_ready), 32'd0);
        tick();
        chk("rel rdy after edge", 32'(load_ready), 32'd1);
        chk_idle("rel");

        // Single word from IDLE; data_in change after accept must be ignored
        load_valid = 1'b1;
        data_in    = 16'hA5C3;
        tick();
        load_valid = 1'b0;
        data_in    = 16'h0000;
        expect_word(16'hA5C3, "a5c3");

        // Back-to-back words with load_valid held high
        w1 = 16'h0001;
        w2 = 16'h8000;
        load_valid = 1'b1;
        data_in    = w1;
        tick();
        data_in = w2;
        for (int i = 0; i < 32; i++) begin
            eb = (i < 16) ? w1[i[3:0]] : w2[i[3:0]];
            chk($sformatf("b2b bit%0d", i), 32'(sout), 32'(eb));
            chk($sformatf("b2b vld%0d", i), 32'(sout_valid), 32'd1);
            chk($sformatf("b2b last%0d", i), 32'(sout_last), 32'(i == 15 || i == 31));
            chk($sformatf("b2b rdy%0d", i), 32'(load_ready), 32'(i == 15 || i == 31));
            if (i == 16) load_valid = 1'b0;
            tick();
        end
        chk_idle("b2b end");

        // Hold for 3 cycles at bit 5: 19 valid cycles, last only on the 19th
        load_valid = 1'b1;
        data_in    = 16'hFFFF;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 19; c++) begin
            chk($sformatf("hold bit c%0d", c), 32'(sout), 32'd1);
            chk($sformatf("hold vld c%0d", c), 32'(sout_valid), 32'd1);
            chk($sformatf("hold last c%0d", c), 32'(sout_last), 32'(c == 18));
            chk($sformatf("hold busy c%0d", c), 32'(busy), 32'd1);
            hold = (c >= 5 && c <= 7);
            chk($sformatf("hold rdy c%0d", c), 32'(load_ready), 32'(c == 18));
            tick();
        end
        hold = 1'b0;
        chk_idle("hold end");

        // CLR mid-word at bit 7 of 16'h1234 aborts immediately
        wc = 16'h1234;
        load_valid = 1'b1;
        data_in    = wc;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("abort bit%0d", i), 32'(sout), 32'(wc[i[3:0]]));
            chk($sformatf("abort vld%0d", i), 32'(sout_valid), 32'd1);
            if (i < 7) tick();
        end
        #3 CLR = 1'b1;
        #1;
        chk_idle("clr async");
        chk("clr async rdy", 32'(load_ready), 32'd0);
        #1 CLR = 1'b0;
        #1 chk("clr rel rdy", 32'(load_ready), 32'd0);
        tick();
        chk_idle("clr post");
        chk("clr post rdy", 32'(load_ready), 32'd1);
        tick();
        chk_idle("clr no resend");

        load_valid = 1'b1;
        data_in    = 16'h0003;
        tick();
        load_valid = 1'b0;
        expect_word(16'h0003, "w0003");

        // hold high in IDLE does not block an accept
        hold       = 1'b1;
        load_valid = 1'b1;
        data_in    = 16'h0002;
        #1 chk("idle hold rdy", 32'(load_ready), 32'd1);
        tick();
        hold       = 1'b0;
        load_valid = 1'b0;
        expect_word(16'h0002, "w0002");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fib_word_serializer.md
Name: fib_word_serializer

Overview:
- Transmit-side counterpart to the registered-mux bit capture cell used in the Fibonacci datapath.
- Accepts a parallel WIDTH-bit Fibonacci result word through a valid/ready handshake.
- Shifts the word out one bit per clock, LSB first, with per-bit valid and last-bit flags.
- Sits between the Fibonacci accumulator registers and the serial bit-capture chain or board output pins.

Parameters:
- WIDTH, 16, bits per word; legal range 2..32.
- CW, 5, width of the internal bit counter; must satisfy 2^CW >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  reset, asynchronous, active-high; clears all state immediately, independent of clk.
- load_valid  input  1  data_in holds a word to send.
- load_ready  output  1  block can accept a word on this edge.
- data_in  input  WIDTH  parallel word; sampled only on a handshake edge.
- hold  input  1  stall; when high during SHIFT, the current bit is held and nothing advances.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid bit.
- sout_last  output  1  sout is bit WIDTH-1 of the current word.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (CLR=1, asynchronous):
  - state=IDLE, shift register=0, counter=0.
  - Outputs: sout=0, sout_valid=0, sout_last=0, busy=0.
  - load_ready=0 while CLR is high, and 1 from the first clk edge after release.
- Handshake: a word is accepted on a rising edge where load_valid=1 and load_ready=1.
- load_ready is combinational: (state==IDLE) | (state==SHIFT & sout_last & ~hold).
- States:
  - IDLE: sout_valid=0, sout=0. On accept, go to SHIFT: shreg<=data_in, counter<=0, sout<=data_in[0].
  - SHIFT: sout_valid=1, sout=shreg[0], sout_last=(counter==WIDTH-1).
    - Edge with hold=1: no change to shreg, counter or outputs.
    - Edge with hold=0 and counter<WIDTH-1: shreg shifts right by 1, counter increments.
    - Edge with hold=0 and counter==WIDTH-1, accept: reload from data_in, counter<=0, remain in SHIFT. Back-to-back words, no gap cycle.
    - Edge with hold=0 and counter==WIDTH-1, no accept: return to IDLE.
- Latency: bit0 appears on sout in the cycle right after the accepting edge. A word occupies exactly WIDTH unheld cycles of sout_valid.
- data_in changes outside the accepting edge have no effect.
- hold while IDLE is ignored and does not block an accept.
- load_valid during mid-word SHIFT is not accepted; the upstream holds the word until load_ready.
- CLR mid-word aborts the word; there is no partial output afterwards and the word is not resent.
- All outputs are registered except load_ready.

Test Plan:
- CLR pulse asynchronous to clk, mid-cycle -> all outputs 0 immediately without a clk edge; load_ready=1 after the first edge after release.
- WIDTH=16, load 16'hA5C3 from IDLE -> sout bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on 16 consecutive cycles; sout_last only on the 16th; then busy=0.
- Back-to-back: 16'h0001 then 16'h8000, load_valid held high -> 32 contiguous valid cycles; load_ready high only on the last-bit cycle; second word's bit0 follows the first word's bit15 with no gap.
- hold asserted 3 cycles at bit 5 of 16'hFFFF -> sout_valid stays 1 and bit 5 repeats for 4 total cycles; the word completes after 19 valid cycles.
- CLR asserted at bit 7 of 16'h1234 -> immediate IDLE, sout_valid=0; the next load 16'h0003 serializes cleanly as 1,1,0,...
- hold=1 in IDLE with load of 16'h0002 -> accepted on the same edge; bit0=0, bit1=1.
